// File: rtl/lzw_pkg.sv
// Shared types and constants for the LZW decoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: literal/string-size constants, FSM state enum, dictionary entry
// layout (64-bit string with byte 0 as the first character, plus length),
// and a helper that overwrites one byte of a string.
package lzw_pkg;

  localparam int LIT_CODES     = 256;
  localparam int MAX_STR_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EMIT,
    UPDATE
  } state_t;

  typedef struct packed {
    logic [63:0] str;
    logic [3:0]  len;
  } dict_entry_t;

  // Returns s with byte position pos replaced by b. Positions >= 8 leave s unchanged.
  function automatic logic [63:0] put_byte(logic [63:0] s, logic [3:0] pos, logic [7:0] b);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < MAX_STR_BYTES; i++) begin
      if (pos == 4'(i)) r[i*8 +: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/lzw_dict_ram.sv
// Dictionary storage: single-port synchronous RAM of dict_entry_t words.
// Latency: 1 cycle read (rdata valid the cycle after addr is presented).
// Backpressure: none; a write cycle does not update rdata.
// Ports: clk, we (write strobe), addr, wdata, rdata.
module lzw_dict_ram
  import lzw_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  dict_entry_t           wdata,
  output dict_entry_t           rdata
);

  dict_entry_t mem [0:(1<<ADDR_WIDTH)-1];

  // Contents are never cleared: the decoder only reads codes below its
  // next_code pointer, so stale words are unreachable after a reset or clear.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/lzw_decoder.sv
// Streaming LZW decompressor: codes in, dictionary rebuilt on the fly, bytes out.
// Latency: accept cycle + 1 LOOKUP cycle, then one byte per cycle; cur_len+3 cycles per code.
// Backpressure: byte_ready low holds byte_out/idx; code_ready is high only in IDLE.
// Ports: clk, rst (async, active-high); code_in/code_valid/code_ready (code stream);
// dict_clr (clear pulse, honoured in IDLE); byte_out/byte_valid/byte_ready (byte
// stream); err (sticky illegal-code flag); busy (FSM not in IDLE).
module lzw_decoder
  import lzw_pkg::*;
#(
  parameter int HASH_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HASH_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic                  dict_clr,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  err,
  output logic                  busy
);

  localparam logic [HASH_WIDTH:0] FIRST_FREE = (HASH_WIDTH+1)'(LIT_CODES);
  // 2^HASH_WIDTH: next_code parks here once every code has been assigned.
  localparam logic [HASH_WIDTH:0] CODE_LIMIT = {1'b1, {HASH_WIDTH{1'b0}}};

  state_t                  state;
  state_t                  state_nxt;
  logic [HASH_WIDTH-1:0]   code_q;
  logic [HASH_WIDTH:0]     code_ext;
  logic [HASH_WIDTH:0]     next_code;
  logic                    have_prev;
  logic [DATA_WIDTH-1:0]   prev_str;
  logic [3:0]              prev_len;
  logic [DATA_WIDTH-1:0]   cur_str;
  logic [3:0]              cur_len;
  logic [3:0]              idx;

  logic                    room;
  logic                    lookup_ok;
  logic [DATA_WIDTH-1:0]   look_str;
  logic [3:0]              look_len;
  logic                    emit_last;
  logic                    ram_we;
  logic [HASH_WIDTH-1:0]   ram_addr;
  dict_entry_t             ram_wdata;
  dict_entry_t             ram_rdata;

  assign code_ext = {1'b0, code_q};

  // A new entry (prev + one byte) fits only if prev is shorter than the
  // maximum string and a free code remains.
  assign room = (prev_len < 4'(MAX_STR_BYTES)) && (next_code < CODE_LIMIT);

  assign emit_last = byte_valid && byte_ready && (idx == cur_len - 4'd1);

  // Single port: UPDATE owns the port for its write; every other cycle reads
  // code_in so the data for an accepted code is ready in LOOKUP.
  assign ram_we    = (state == UPDATE) && have_prev && room;
  assign ram_addr  = ram_we ? next_code[HASH_WIDTH-1:0] : code_in;
  assign ram_wdata = '{str: put_byte(prev_str, prev_len, cur_str[7:0]),
                       len: prev_len + 4'd1};

  lzw_dict_ram #(
    .ADDR_WIDTH (HASH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Resolve the string for code_q. The KwKwK case (code not yet in the
  // dictionary because the encoder just created it) is prev + prev's first byte.
  always_comb begin
    look_str  = '0;
    look_len  = '0;
    lookup_ok = 1'b0;
    if (code_ext < FIRST_FREE) begin
      look_str  = DATA_WIDTH'(code_q[7:0]);
      look_len  = 4'd1;
      lookup_ok = 1'b1;
    end else if (code_ext < next_code) begin
      look_str  = ram_rdata.str;
      look_len  = ram_rdata.len;
      lookup_ok = 1'b1;
    end else if ((code_ext == next_code) && have_prev && room) begin
      look_str  = put_byte(prev_str, prev_len, prev_str[7:0]);
      look_len  = prev_len + 4'd1;
      lookup_ok = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!dict_clr && code_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = lookup_ok ? EMIT : IDLE;
      EMIT:    if (emit_last) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: purely state-decoded so rst drops byte_valid immediately.
  always_comb begin
    code_ready = (state == IDLE);
    busy       = (state != IDLE);
    byte_valid = (state == EMIT);
    byte_out   = byte_valid ? cur_str[{idx[2:0], 3'b000} +: 8] : 8'd0;
  end

  // Datapath: code latch, string registers, dictionary pointer, error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q    <= '0;
      next_code <= FIRST_FREE;
      have_prev <= 1'b0;
      prev_str  <= '0;
      prev_len  <= '0;
      cur_str   <= '0;
      cur_len   <= '0;
      idx       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dict_clr) begin
            next_code <= FIRST_FREE;
            have_prev <= 1'b0;
            err       <= 1'b0;
          end else if (code_valid) begin
            code_q <= code_in;
          end
        end
        LOOKUP: begin
          if (lookup_ok) begin
            cur_str <= look_str;
            cur_len <= look_len;
            idx     <= '0;
          end else begin
            err <= 1'b1;
          end
        end
        EMIT: begin
          if (byte_valid && byte_ready) idx <= idx + 4'd1;
        end
        UPDATE: begin
          if (have_prev && room) next_code <= next_code + 1'b1;
          prev_str  <= cur_str;
          prev_len  <= cur_len;
          have_prev <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
